fifo_rblock_fwft: RTL and testbench
===================================

# fifo_rblock_fwft

Read-side controller of the asynchronous FIFO, running entirely in the read clock domain. It sits directly downstream of the FIFO memory and write block. It synchronises the write pointer into `rclk`, drives the memory read address, and detects empty and almost-empty conditions. It presents the memory output through a first-word-fall-through (FWFT) output register with a valid/ready handshake, and returns its own Gray-coded read pointer for the write side's full detection.

## Interface
- `ADDR_W`, 23, memory address width; pointers are `ADDR_W+1` bits (MSB = wrap bit)
- `DATA_W`, 8, data word width
- `AEMPTY_THRESH`, 4, `aempty` asserts when words in memory (excluding output register) <= this value
- `rclk`  in  1  read clock; only clock of the block
- `rrst_n`  in  1  asynchronous active-low reset
- `wptr_gray`  in  ADDR_W+1  write pointer, Gray-coded and registered in write domain (asynchronous to `rclk`)
- `rdata_mem`  in  DATA_W  memory read data, combinational from `raddr`
- `raddr`  out  ADDR_W  memory read address
- `rptr_gray`  out  ADDR_W+1  registered Gray read pointer to write domain
- `dout`  out  DATA_W  output data
- `dout_valid`  out  1  `dout` holds a valid word
- `dout_ready`  in  1  consumer accepts `dout` this cycle
- `rempty`  out  1  memory holds no unread word (output register not counted)
- `aempty`  out  1  almost empty
- `rlevel`  out  ADDR_W+1  words in memory not yet fetched

## Operation
- Synchroniser: two flops `wq1`, `wq2` (reset 0) capture `wptr_gray`. `wq2_bin` = Gray-to-binary of `wq2`. No other logic samples `wptr_gray`.
- `rbin`: binary read pointer, ADDR_W+1 bits, reset 0. `raddr = rbin[ADDR_W-1:0]`.
- `fetch = !rempty && (!dout_valid || dout_ready)`.
- `rbin_next = rbin + fetch`, mod 2^(ADDR_W+1). `rgray_next = rbin_next ^ (rbin_next >> 1)`.
- Each edge:
  - `rbin <= rbin_next`
  - `rptr_gray <= rgray_next`
  - `rempty <= (rgray_next == wq2)`
  - `rlevel <= wq2_bin - rbin_next` (mod 2^(ADDR_W+1))
  - `aempty <= (wq2_bin - rbin_next) <= AEMPTY_THRESH`
- Output register:
  - On `fetch`: `dout <= rdata_mem`, `dout_valid <= 1`.
  - Else if `dout_valid && dout_ready`: `dout_valid <= 0`, `dout` holds.
- Handshake: a word transfers on any edge with `dout_valid && dout_ready`. `dout` is stable while `dout_valid && !dout_ready`. Fetch and consume in the same cycle replace the word with no bubble.
- Invariant: `rempty == (rlevel == 0)` after every edge.
- Reset values (async on `rrst_n` low):
  - `wq1`, `wq2`, `rbin`, `rptr_gray`, `rlevel`, `dout`, `dout_valid` = 0
  - `rempty` = 1, `aempty` = 1
- Reset mid-operation: all of the above apply immediately, and the word in `dout` is discarded. The write side is reset in the same event; this block does not sequence that reset.
- Wrap-around: pointers wrap naturally at 2^(ADDR_W+1). Empty detection uses the full Gray compare, so equal addresses with different wrap bits are never empty.
- Read side never reads past `wq2`. Pessimistic `rempty` from synchroniser lag is permitted; an optimistic one is not.

## Timing
- Latency, empty FIFO, `wptr_gray` changes before `rclk` edge E1:
  - E1: `wq1`
  - E2: `wq2`
  - E3: `rempty` = 0, `rlevel` updates
  - E4: `dout_valid` = 1 with the word
- Throughput: one word per `rclk` with `dout_ready` held high and data available.
- Last word: `rempty` returns to 1 on the same edge that fetches it, with no extra fetch.
- `rptr_gray` is registered, changes at most one bit per edge, and is safe for the write-side synchroniser.

## Test plan
Bench uses `ADDR_W`=3, `AEMPTY_THRESH`=2, and a behavioural memory model.
- **Reset:** hold `rrst_n`=0 with random inputs -> `rempty`=1, `aempty`=1, `dout_valid`=0, `raddr`=0, `rptr_gray`=0, `rlevel`=0. Reassert low mid-burst -> same values asynchronously, before the next edge.
- **Single word:** `MEM[0]`=0xA5, `wptr_gray` 0->1, `dout_ready`=1.
  - `dout_valid`=1 with `dout`=0xA5 at E4.
  - `rptr_gray`=1 and `rempty`=1 at E4.
  - `dout_valid`=0 one edge later.
- **Full burst:** 8 words 0x10..0x17, `wptr_gray`=0b1100, `dout_ready`=1.
  - `rlevel`=8 at E3.
  - 8 consecutive valid cycles, `raddr` 0..7, data in order.
  - `aempty` rises when `rlevel` <= 2.
  - Ends with `rptr_gray`=0b1100, `rempty`=1.
- **Backpressure:** 3 words written, `dout_ready`=0.
  - Exactly one fetch occurs; `dout` is held stable; `rlevel`=2.
  - Raise `dout_ready` -> remaining words delivered in order, none dropped or duplicated.
- **Wrap:** 20 words written in chunks of <=8 across the 4-bit pointer wrap (15->0).
  - Order preserved.
  - `rempty` only when Gray pointers are equal.
  - Never empty when addresses match with different wrap bits.
- **Random CDC:** random `wptr_gray` advances (Gray, one step at a time, asynchronous timing) and random `dout_ready` -> scoreboard matches, `rempty==(rlevel==0)` holds every edge, no read beyond the synchronised write pointer.

Source files
------------

// File: rtl/fifo_rblock_fwft.sv
`default_nettype none
// ============================================================================
// fifo_rblock_fwft : async FIFO read-side controller with FWFT output register
// Revision: 1.0
// ============================================================================
module fifo_rblock_fwft #(
    parameter int ADDR_W        = 23,
    parameter int DATA_W        = 8,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic [ADDR_W:0]   wptr_gray,
    input  logic [DATA_W-1:0] rdata_mem,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   rptr_gray,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              rempty,
    output logic              aempty,
    output logic [ADDR_W:0]   rlevel
);

    localparam logic [ADDR_W:0] AEMPTY_LIM = (ADDR_W+1)'(AEMPTY_THRESH);

    logic [ADDR_W:0]   wq1_q, wq2_q;
    logic [ADDR_W:0]   rbin_q, rgray_q, rlevel_q;
    logic              rempty_q, aempty_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;

    logic [ADDR_W:0]   wq2_bin;
    logic [ADDR_W:0]   rbin_d, rgray_d, level_d;
    logic [DATA_W-1:0] dout_d;
    logic              dout_valid_d;
    logic              fetch;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wq2_bin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            wq2_bin[i] = ^(wq2_q >> i);
        end
    end

    always_comb begin
        fetch   = !rempty_q && (!dout_valid_q || dout_ready);
        rbin_d  = rbin_q + {{ADDR_W{1'b0}}, fetch};
        rgray_d = rbin_d ^ (rbin_d >> 1);
        level_d = wq2_bin - rbin_d;

        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (fetch) begin
            dout_d       = rdata_mem;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wq1_q        <= '0;
            wq2_q        <= '0;
            rbin_q       <= '0;
            rgray_q      <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            aempty_q     <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wq1_q        <= wptr_gray;
            wq2_q        <= wq1_q;
            rbin_q       <= rbin_d;
            rgray_q      <= rgray_d;
            rlevel_q     <= level_d;
            // Full Gray compare: same address with a different wrap bit is not empty.
            rempty_q     <= (rgray_d == wq2_q);
            aempty_q     <= (level_d <= AEMPTY_LIM);
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign raddr      = rbin_q[ADDR_W-1:0];
    assign rptr_gray  = rgray_q;
    assign rlevel     = rlevel_q;
    assign rempty     = rempty_q;
    assign aempty     = aempty_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rblock_fwft.sv
`default_nettype none
// ============================================================================
// tb_fifo_rblock_fwft : randomized + directed bench with a count-based model
// Revision: 1.0
// ============================================================================
module tb_fifo_rblock_fwft;

    logic       rclk;
    logic       rrst_n;
    logic [3:0] wptr_gray;
    logic [7:0] rdata_mem;
    logic [2:0] raddr;
    logic [3:0] rptr_gray;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       rempty;
    logic       aempty;
    logic [3:0] rlevel;

    fifo_rblock_fwft #(.ADDR_W(3), .DATA_W(8), .AEMPTY_THRESH(2)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .rdata_mem(rdata_mem),
        .raddr(raddr), .rptr_gray(rptr_gray), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .rempty(rempty), .aempty(aempty), .rlevel(rlevel)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    logic [7:0] mem [8];
    assign rdata_mem = mem[raddr];

    int checks = 0;
    int errors = 0;
    int rx     = 0;
    bit cmp_en = 0;

    // Model: counts of words written / synchronised / fetched, plus a data history.
    logic [7:0] hist [4096];
    int         written = 0;
    int         s1, s2, m_fetched, m_level;
    logic       m_empty, m_aempty, m_valid, m_fetch;
    logic [7:0] m_dout;

    function automatic logic [3:0] g4(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[written % 8] = d;
        hist[written]    = d;
        written++;
        wptr_gray = g4(written);
    endtask

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            s1 = 0; s2 = 0; m_fetched = 0; m_level = 0;
            m_empty = 1'b1; m_aempty = 1'b1; m_valid = 1'b0; m_dout = 8'h00;
        end else begin
            m_fetch = !m_empty && (!m_valid || dout_ready);
            if (m_fetch) begin
                m_dout  = hist[m_fetched];
                m_valid = 1'b1;
                m_fetched++;
            end else if (m_valid && dout_ready) begin
                m_valid = 1'b0;
            end
            m_level  = s2 - m_fetched;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= 2);
            s2 = s1;
            s1 = written;
        end
    end

    always @(negedge rclk) begin
        if (rrst_n && cmp_en) begin
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("dout",       32'(dout),       32'(m_dout));
            chk("raddr",      32'(raddr),      32'(m_fetched % 8));
            chk("rptr_gray",  32'(rptr_gray),  32'(g4(m_fetched)));
            chk("rempty",     32'(rempty),     32'(m_empty));
            chk("aempty",     32'(aempty),     32'(m_aempty));
            chk("rlevel",     32'(rlevel),     32'(m_level));
            chk("empty_inv",  32'(rempty),     32'(rlevel == 4'd0));
            if (dout_valid && dout_ready) rx++;
        end
    end

    task automatic check_reset(input string nm);
        chk({nm, "_rempty"},     32'(rempty),     32'd1);
        chk({nm, "_aempty"},     32'(aempty),     32'd1);
        chk({nm, "_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({nm, "_raddr"},      32'(raddr),      32'd0);
        chk({nm, "_rptr_gray"},  32'(rptr_gray),  32'd0);
        chk({nm, "_rlevel"},     32'(rlevel),     32'd0);
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n    = 1'b0;
        written   = 0;
        wptr_gray = 4'd0;
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((!m_empty || m_valid || written != m_fetched) && n < 100) begin
            @(negedge rclk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles expected < 100", nm, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int total;
        int chunk;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rrst_n = 1'b0; wptr_gray = 4'd0; dout_ready = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            wptr_gray  = 4'($urandom);
            dout_ready = 1'($urandom);
            #1 check_reset("rst_hold");
        end
        @(negedge rclk);
        wptr_gray = 4'd0; dout_ready = 1'b0; written = 0;
        rrst_n = 1'b1; cmp_en = 1'b1;

        // Single word
        @(negedge rclk);
        dout_ready = 1'b1;
        push(8'hA5);
        repeat (3) @(negedge rclk);
        chk("sw_E3_rempty", 32'(rempty), 32'd0);
        chk("sw_E3_rlevel", 32'(rlevel), 32'd1);
        @(negedge rclk);
        chk("sw_E4_valid",  32'(dout_valid), 32'd1);
        chk("sw_E4_dout",   32'(dout),       32'hA5);
        chk("sw_E4_rptr",   32'(rptr_gray),  32'd1);
        chk("sw_E4_rempty", 32'(rempty),     32'd1);
        @(negedge rclk);
        chk("sw_E5_valid",  32'(dout_valid), 32'd0);

        // Full burst from a fresh reset
        do_reset();
        for (int k = 0; k < 8; k++) push(8'h10 + 8'(k));
        chk("fb_wptr", 32'(wptr_gray), 32'hC);
        repeat (3) @(negedge rclk);
        chk("fb_E3_rlevel", 32'(rlevel), 32'd8);
        chk("fb_E3_aempty", 32'(aempty), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("fb_raddr", 32'(raddr), 32'(k));
            @(negedge rclk);
            chk("fb_valid",  32'(dout_valid), 32'd1);
            chk("fb_dout",   32'(dout),       32'h10 + 32'(k));
            chk("fb_aempty", 32'(aempty),     32'(k >= 5));
        end
        chk("fb_end_rptr",   32'(rptr_gray), 32'hC);
        chk("fb_end_rempty", 32'(rempty),    32'd1);
        @(negedge rclk);
        chk("fb_end_valid",  32'(dout_valid), 32'd0);

        // Backpressure
        dout_ready = 1'b0;
        push(8'h31); push(8'h32); push(8'h33);
        repeat (6) @(negedge rclk);
        for (int k = 0; k < 3; k++) begin
            @(negedge rclk);
            chk("bp_rlevel", 32'(rlevel),     32'd2);
            chk("bp_valid",  32'(dout_valid), 32'd1);
            chk("bp_dout",   32'(dout),       32'h31);
        end
        base = rx;
        @(posedge rclk);
        #1 dout_ready = 1'b1;
        drain("bp");
        chk("bp_delivered", 32'(rx - base), 32'd3);

        // Wrap: 20 words in chunks across the 15->0 pointer wrap
        total = 0;
        base  = rx;
        while (total < 20) begin
            chunk = int'($urandom_range(1, 8));
            if (chunk > 20 - total) chunk = 20 - total;
            @(negedge rclk);
            for (int k = 0; k < chunk; k++) push(8'($urandom));
            total += chunk;
            drain("wrap");
        end
        chk("wrap_delivered", 32'(rx - base), 32'd20);
        chk("wrap_written",   32'(written),   32'd31);

        // Random CDC traffic
        fork
            begin
                repeat (1500) begin
                    @(posedge rclk);
                    #($urandom_range(1, 9));
                    if ($urandom_range(0, 2) != 0 && written - m_fetched < 8) push(8'($urandom));
                end
            end
            begin
                repeat (1500) begin
                    @(posedge rclk);
                    #1 dout_ready = 1'($urandom);
                end
            end
        join
        @(posedge rclk);
        #1 dout_ready = 1'b1;
        drain("rand");

        // Asynchronous reset mid-burst
        @(negedge rclk);
        for (int k = 0; k < 6; k++) push(8'h50 + 8'(k));
        repeat (4) @(negedge rclk);
        @(posedge rclk);
        #3 rrst_n = 1'b0;
        #1 check_reset("mid_rst");
        written = 0; wptr_gray = 4'd0;
        @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
        push(8'hC3); push(8'h3C);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
